fetch_exec_controller: RTL and testbench
========================================

FETCH_EXEC_CONTROLLER -- requirements
Module: fetch_exec_controller

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 mem_rdata  input  16  memory read data; valid the cycle after the memory samples mem_addr (synchronous read, 1-cycle latency).
REQ-006 mem_addr  output  16  memory address; always equals the internal MAR register.
REQ-007 mem_wdata  output  16  memory write data; always equals ac.
REQ-008 mem_we  output  1  memory write enable.
REQ-009 pc  output  16  program counter.
REQ-010 ac  output  16  accumulator.
REQ-011 ir  output  16  instruction register.
REQ-012 busy  output  1  high in every state except IDLE and HALT.
REQ-013 halted  output  1  high while in HALT.
REQ-014 illegal  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-015 States: IDLE, F0, F1, F2, DEC, M0, M1, ST, HALT; one state per cycle.
REQ-016 IDLE: start=1 -> F0; otherwise stay in IDLE.
REQ-017 F0: MAR<=pc; -> F1. F1: wait, memory samples MAR; -> F2. F2: ir<=mem_rdata, pc<=pc+1 (FFFF wraps to 0000); -> DEC.
REQ-018 Instruction format: opcode ir[15:12], operand X ir[11:0], zero-extended to 16 bits.
REQ-019 DEC, opcodes 1 LOAD, 3 ADD, 4 SUBT: MAR<=X; -> M0. M0: wait; -> M1.
REQ-020 M1: LOAD ac<=mem_rdata; ADD ac<=ac+mem_rdata; SUBT ac<=ac-mem_rdata; all modulo 2^16, no flags; -> F0.
REQ-021 DEC, opcode 2 STORE: MAR<=X; -> ST. ST: mem_we=1, memory writes ac at the edge ending ST; -> F0.
REQ-022 mem_we is 1 only in ST and 0 in every other state.
REQ-023 DEC, opcode 9 JUMP: pc<=X; -> F0.
REQ-024 DEC, opcode A CLEAR: ac<=0000; -> F0.
REQ-025 DEC, opcode 8 SKIPCOND on ir[11:10]: 00 skips if ac[15]=1; 01 skips if ac=0000; 10 skips if ac!=0000 and ac[15]=0; 11 never skips. A skip sets pc<=pc+1 (wrapping). -> F0.
REQ-026 DEC, opcode 7 HALT: -> HALT. HALT is left only by reset; start is ignored.
REQ-027 DEC, opcodes 0, 5, 6, B-F: no change to pc, ac or memory; illegal=1 in the following cycle only; -> F0.
REQ-028 Cycles per instruction: LOAD/ADD/SUBT 6, STORE 5, JUMP/CLEAR/SKIPCOND/illegal 4.
REQ-029 start is ignored in every state except IDLE.

Reset
REQ-030 reset sampled high at a clock edge, in any state: state<=IDLE, pc<=RESET_PC, ac<=0000, ir<=0000, MAR<=0000.
REQ-031 After that edge, mem_we=0, busy=0, halted=0 and illegal=0.
REQ-032 A reset asserted during ST aborts the write.
REQ-033 reset has priority over start and over all state transitions.

Verification
REQ-034 Program run: M[0]=1010, M[1]=3011, M[2]=2012, M[3]=7000, M[10]=0005, M[11]=0007; reset, then start -> M[12]=000C, ac=000C, pc=0004, halted=1, exactly 21 cycles after IDLE->F0.
REQ-035 SUBT wrap and skip: M[0]=A000, M[1]=4010, M[2]=8000, M[3]=9030, M[4]=7000, M[10]=0001 -> ac=FFFF; JUMP at M[3] skipped; halts with pc=0005.
REQ-036 JUMP: M[0]=9020, M[20]=7000 -> pc=0020 after DEC; next F1 shows mem_addr=0020; halted with pc=0021.
REQ-037 Illegal opcode: M[0]=F123, M[1]=7000 -> illegal high for exactly one cycle (the F0 after DEC); ac unchanged; no mem_we; halts with pc=0002.
REQ-038 Reset mid-store: assert reset in the ST cycle of 2012 with ac=1234 -> M[12] unchanged, mem_we=0 and state IDLE on the next cycle, pc=RESET_PC, ac=0000.
REQ-039 Start gating: start=1 while halted or busy -> no state change; start=1 in IDLE -> busy=1 the next cycle.

Source files
------------

// File: rtl/fetch_exec_controller.sv
// Multi-cycle accumulator-machine controller: fetches 16-bit instructions from a
// synchronous-read memory and executes LOAD/STORE/ADD/SUBT/JUMP/CLEAR/SKIPCOND/HALT.
module fetch_exec_controller #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic [15:0] pc,
    output logic [15:0] ac,
    output logic [15:0] ir,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);

    localparam int unsigned DW = 16;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_F0   = 4'd1;
    localparam logic [3:0] S_F1   = 4'd2;
    localparam logic [3:0] S_F2   = 4'd3;
    localparam logic [3:0] S_DEC  = 4'd4;
    localparam logic [3:0] S_M0   = 4'd5;
    localparam logic [3:0] S_M1   = 4'd6;
    localparam logic [3:0] S_ST   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUBT  = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_CLEAR = 4'hA;

    logic [3:0]    state, state_next;
    logic [DW-1:0] mar, mar_next;
    logic [DW-1:0] pc_next, ac_next, ir_next;
    logic          illegal_next, busy_next, halted_next;
    logic [3:0]    opcode;
    logic [DW-1:0] operand;
    logic          skip;

    assign opcode    = ir[15:12];
    assign operand   = {4'h0, ir[11:0]};
    assign mem_addr  = mar;
    assign mem_wdata = ac;
    // Gated by reset so a reset landing on the ST cycle suppresses the write edge.
    assign mem_we    = (state == S_ST) && !reset;

    always_comb begin
        unique case (ir[11:10])
            2'b00:   skip = ac[15];
            2'b01:   skip = (ac == 16'h0000);
            2'b10:   skip = (ac != 16'h0000) && !ac[15];
            default: skip = 1'b0;
        endcase
    end

    // Next-state and next-register-value logic.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        ac_next      = ac;
        ir_next      = ir;
        mar_next     = mar;
        illegal_next = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_next = S_F0;
            S_F0: begin
                mar_next   = pc;
                state_next = S_F1;
            end
            S_F1: state_next = S_F2;
            S_F2: begin
                ir_next    = mem_rdata;
                pc_next    = pc + 16'd1;
                state_next = S_DEC;
            end
            S_DEC: begin
                state_next = S_F0;
                unique case (opcode)
                    OP_LOAD, OP_ADD, OP_SUBT: begin
                        mar_next   = operand;
                        state_next = S_M0;
                    end
                    OP_STORE: begin
                        mar_next   = operand;
                        state_next = S_ST;
                    end
                    OP_JUMP:  pc_next = operand;
                    OP_CLEAR: ac_next = 16'h0000;
                    OP_SKIP:  if (skip) pc_next = pc + 16'd1;
                    OP_HALT:  state_next = S_HALT;
                    default:  illegal_next = 1'b1;
                endcase
            end
            S_M0: state_next = S_M1;
            S_M1: begin
                unique case (opcode)
                    OP_LOAD: ac_next = mem_rdata;
                    OP_ADD:  ac_next = ac + mem_rdata;
                    OP_SUBT: ac_next = ac - mem_rdata;
                    default: ac_next = ac;
                endcase
                state_next = S_F0;
            end
            S_ST:   state_next = S_F0;
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
        busy_next   = (state_next != S_IDLE) && (state_next != S_HALT);
        halted_next = (state_next == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            ac      <= 16'h0000;
            ir      <= 16'h0000;
            mar     <= 16'h0000;
            busy    <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            ac      <= ac_next;
            ir      <= ir_next;
            mar     <= mar_next;
            busy    <= busy_next;
            halted  <= halted_next;
            illegal <= illegal_next;
        end
    end

endmodule

// File: tb/tb_fetch_exec_controller.sv
// Program-level bench: loads small programs into a synchronous memory model and
// checks final architectural state, cycle counts and pulse behaviour via a scoreboard.
module tb_fetch_exec_controller;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] mem_rdata, mem_addr, mem_wdata, pc, ac, ir;
    logic        mem_we, busy, halted, illegal;

    always #5 clk = ~clk;

    fetch_exec_controller #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .pc(pc), .ac(ac), .ir(ir), .busy(busy), .halted(halted), .illegal(illegal)
    );

    // Synchronous-read memory with a bench-side load port.
    logic [15:0] mem [256];
    logic        ld_en, ld_clr;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    always @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[7:0]];
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          cycles, ill_cnt, ill_at, we_cnt;
    logic [15:0] pc_hist   [256];
    logic [15:0] addr_hist [256];
    string       sb_tag [$];
    logic [15:0] sb_val [$];
    logic [15:0] skip_vals [4] = '{16'h8000, 16'h0000, 16'h0001, 16'h7FFF};

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] observe(input string t);
        if (t == "ac")      return ac;
        if (t == "pc")      return pc;
        if (t == "halted")  return 16'(halted);
        if (t == "cyc")     return 16'(cycles);
        if (t == "m12")     return mem[8'h12];
        if (t == "ill")     return 16'(ill_cnt);
        if (t == "ill_at")  return 16'(ill_at);
        if (t == "we")      return 16'(we_cnt);
        if (t == "pc_c4")   return pc_hist[4];
        if (t == "addr_c5") return addr_hist[5];
        return 16'hDEAD;
    endfunction

    task automatic sb_push(input string t, input logic [15:0] v);
        sb_tag.push_back(t);
        sb_val.push_back(v);
    endtask

    task automatic sb_drain();
        string       t;
        logic [15:0] v;
        while (sb_tag.size() > 0) begin
            t = sb_tag.pop_front();
            v = sb_val.pop_front();
            check_eq(t, observe(t), v);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Holds reset, clears memory; caller then pokes the program.
    task automatic begin_prog();
        reset  = 1'b1;
        start  = 1'b0;
        ld_clr = 1'b1;
        @(negedge clk);
        ld_clr = 1'b0;
    endtask

    // Releases reset, checks reset state, starts, and runs until halt or stop_at.
    task automatic run(input int stop_at, input bit hold_start);
        bit timed_out;
        reset = 1'b0;
        check_eq("rst_pc", pc, 16'h0000);
        check_eq("rst_ac", ac, 16'h0000);
        check_eq("rst_ir", ir, 16'h0000);
        check_eq("rst_addr", mem_addr, 16'h0000);
        check_eq("rst_flags", {12'h0, busy, halted, mem_we, illegal}, 16'h0000);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        check_eq("busy_after_start", 16'(busy), 16'h0001);
        cycles = 0; ill_cnt = 0; ill_at = 0; we_cnt = 0;
        timed_out = 1'b1;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            pc_hist[cycles]   = pc;
            addr_hist[cycles] = mem_addr;
            if (illegal) begin ill_cnt++; ill_at = cycles; end
            if (mem_we) we_cnt++;
            if (halted || (stop_at != 0 && cycles == stop_at)) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) check_eq("halt_timeout", 16'(cycles), 16'hFFFF);
    endtask

    function automatic bit exp_skip(input logic [1:0] c, input logic [15:0] v);
        case (c)
            2'b00:   return v[15];
            2'b01:   return v == 16'h0000;
            2'b10:   return (v != 16'h0000) && !v[15];
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; ld_en = 1'b0; ld_clr = 1'b0;
        ld_addr = 8'h00; ld_data = 16'h0000;
        @(negedge clk);

        // LOAD/ADD/STORE/HALT with start held high throughout
        begin_prog();
        poke(8'h00, 16'h1010); poke(8'h01, 16'h3011); poke(8'h02, 16'h2012);
        poke(8'h03, 16'h7000); poke(8'h10, 16'h0005); poke(8'h11, 16'h0007);
        sb_push("cyc", 16'd21); sb_push("ac", 16'h000C); sb_push("pc", 16'h0004);
        sb_push("m12", 16'h000C); sb_push("we", 16'd1); sb_push("ill", 16'd0);
        run(0, 1'b1);
        sb_drain();
        repeat (3) @(negedge clk);
        sb_push("halted", 16'h0001); sb_push("pc", 16'h0004);
        sb_drain();
        start = 1'b0;

        // CLEAR, SUBT wrap, SKIPCOND skipping a JUMP
        begin_prog();
        poke(8'h00, 16'hA000); poke(8'h01, 16'h4010); poke(8'h02, 16'h8000);
        poke(8'h03, 16'h9030); poke(8'h04, 16'h7000); poke(8'h10, 16'h0001);
        sb_push("cyc", 16'd18); sb_push("ac", 16'hFFFF); sb_push("pc", 16'h0005);
        run(0, 1'b0);
        sb_drain();

        // JUMP
        begin_prog();
        poke(8'h00, 16'h9020); poke(8'h20, 16'h7000);
        sb_push("cyc", 16'd8); sb_push("pc_c4", 16'h0020); sb_push("addr_c5", 16'h0020);
        sb_push("pc", 16'h0021);
        run(0, 1'b0);
        sb_drain();

        // Illegal opcode after a LOAD: ac preserved, one-cycle pulse, no write
        begin_prog();
        poke(8'h00, 16'h1010); poke(8'h01, 16'hF123); poke(8'h02, 16'h7000);
        poke(8'h10, 16'h5A5A);
        sb_push("cyc", 16'd14); sb_push("ill", 16'd1); sb_push("ill_at", 16'd10);
        sb_push("we", 16'd0); sb_push("ac", 16'h5A5A); sb_push("pc", 16'h0003);
        run(0, 1'b0);
        sb_drain();

        // ADD wrap
        begin_prog();
        poke(8'h00, 16'h1010); poke(8'h01, 16'h3011); poke(8'h02, 16'h7000);
        poke(8'h10, 16'hFFFF); poke(8'h11, 16'h0002);
        sb_push("cyc", 16'd16); sb_push("ac", 16'h0001); sb_push("pc", 16'h0003);
        run(0, 1'b0);
        sb_drain();

        // Every SKIPCOND condition against sign/zero/positive accumulators
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                begin_prog();
                poke(8'h00, 16'h1010);
                poke(8'h01, 16'h8000 | (16'(c) << 10));
                poke(8'h02, 16'h7000); poke(8'h03, 16'h7000);
                poke(8'h10, skip_vals[k]);
                sb_push("cyc", 16'd14); sb_push("ac", skip_vals[k]);
                sb_push("pc", exp_skip(2'(c), skip_vals[k]) ? 16'h0004 : 16'h0003);
                run(0, 1'b0);
                sb_drain();
            end
        end

        // Reset landing on the ST cycle of 2012 aborts the write
        begin_prog();
        poke(8'h00, 16'h1010); poke(8'h01, 16'h2012); poke(8'h03, 16'h7000);
        poke(8'h10, 16'h1234); poke(8'h12, 16'hBEEF);
        run(10, 1'b0);
        check_eq("st_we", 16'(mem_we), 16'h0001);
        check_eq("st_ac", ac, 16'h1234);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1;
        check_eq("abort_we", 16'(mem_we), 16'h0000);
        check_eq("abort_idle", {14'h0, busy, halted}, 16'h0000);
        check_eq("abort_pc", pc, 16'h0000);
        check_eq("abort_ac", ac, 16'h0000);
        check_eq("abort_m12", mem[8'h12], 16'hBEEF);
        @(negedge clk);
        check_eq("idle_stays", 16'(busy), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
